// File: rtl/I3CCSR_pkg.sv
// I3CCSR_pkg
// Register-block geometry shared by every CSR CPU-interface client.
// No ports.
package I3CCSR_pkg;

    localparam int unsigned I3CCSR_MIN_ADDR_WIDTH = 12;
    localparam int unsigned I3CCSR_DATA_WIDTH     = 32;

endpackage

// File: rtl/i3c_cpuif_arb_pkg.sv
// i3c_cpuif_arb_pkg
// Types shared by the CSR CPU-interface arbiter: FSM state encoding, the
// captured request record and the requester-count range check.
// No ports.
package i3c_cpuif_arb_pkg;

    import I3CCSR_pkg::*;

    localparam int unsigned NUM_REQ_MIN = 2;
    localparam int unsigned NUM_REQ_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // Request as latched at grant time and replayed downstream.
    typedef struct packed {
        logic                               is_wr;
        logic [I3CCSR_MIN_ADDR_WIDTH-1:0]   addr;
        logic [I3CCSR_DATA_WIDTH-1:0]       wr_data;
        logic [I3CCSR_DATA_WIDTH-1:0]       wr_biten;
    } cpuif_req_t;

    function automatic bit num_req_ok(input int unsigned n);
        return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
    endfunction

endpackage

// File: rtl/i3c_rr_arbiter.sv
// i3c_rr_arbiter
// Combinational round-robin pick: the first asserted request strictly after
// last_grant (wrapping) wins.
// Ports:
//   req        in   NumReq  request vector
//   last_grant in   IdxW    index of the most recently completed owner
//   grant      out  NumReq  one-hot grant (all zero when no request)
module i3c_rr_arbiter #(
    parameter  int unsigned NumReq = 2,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   last_grant,
    output logic [NumReq-1:0] grant
);

    always_comb begin
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        // last_grant itself is visited last, so a lone requester is re-granted.
        for (int unsigned off = 1; off <= NumReq; off++) begin
            idx = (32'(last_grant) + off) % NumReq;
            if (!found && req[idx[IdxW-1:0]]) begin
                grant[idx[IdxW-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csr_cpuif_arbiter.sv
// csr_cpuif_arbiter
// Shares one CSR CPU interface between NumReq requesters, one transaction in
// flight at a time, with round-robin fairness and a downstream ack timeout.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   s_req_i .. s_wr_biten_i      per-requester level request and payload
//   s_stall_o                    requester pending and not completed this cycle
//   s_rd/wr_ack_o, s_rd/wr_err_o completion strobes routed to the owner only
//   s_rd_data_o                  shared read data, valid with s_rd_ack_o
//   m_cpuif_*                    downstream request / stall / completion
//   timeout_o                    sticky flag, set by any forced-timeout completion
module csr_cpuif_arbiter
    import I3CCSR_pkg::*;
    import i3c_cpuif_arb_pkg::*;
#(
    parameter  int unsigned NumReq        = 2,
    parameter  int unsigned TimeoutCycles = 255,
    localparam int unsigned CsrAddrWidth  = I3CCSR_MIN_ADDR_WIDTH,
    localparam int unsigned CsrDataWidth  = I3CCSR_DATA_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,

    input  logic [NumReq-1:0]                    s_req_i,
    input  logic [NumReq-1:0]                    s_req_is_wr_i,
    input  logic [NumReq-1:0][CsrAddrWidth-1:0]  s_addr_i,
    input  logic [NumReq-1:0][CsrDataWidth-1:0]  s_wr_data_i,
    input  logic [NumReq-1:0][CsrDataWidth-1:0]  s_wr_biten_i,
    output logic [NumReq-1:0]                    s_stall_o,
    output logic [NumReq-1:0]                    s_rd_ack_o,
    output logic [NumReq-1:0]                    s_rd_err_o,
    output logic [NumReq-1:0]                    s_wr_ack_o,
    output logic [NumReq-1:0]                    s_wr_err_o,
    output logic [CsrDataWidth-1:0]              s_rd_data_o,

    output logic                                 m_cpuif_req,
    output logic                                 m_cpuif_req_is_wr,
    output logic [CsrAddrWidth-1:0]              m_cpuif_addr,
    output logic [CsrDataWidth-1:0]              m_cpuif_wr_data,
    output logic [CsrDataWidth-1:0]              m_cpuif_wr_biten,
    input  logic                                 m_cpuif_req_stall_wr,
    input  logic                                 m_cpuif_req_stall_rd,
    input  logic                                 m_cpuif_rd_ack,
    input  logic                                 m_cpuif_rd_err,
    input  logic                                 m_cpuif_wr_ack,
    input  logic                                 m_cpuif_wr_err,
    input  logic [CsrDataWidth-1:0]              m_cpuif_rd_data,

    output logic                                 timeout_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    if (!num_req_ok(NumReq)) begin : g_bad_num_req
        $error("csr_cpuif_arbiter: NumReq must be in 2..4");
    end

    arb_state_e        state;
    logic [IdxW-1:0]   owner;
    logic [IdxW-1:0]   last_grant;
    cpuif_req_t        cap;
    logic [CntW-1:0]   cnt;
    logic              req_q;
    logic              timeout_q;

    logic [NumReq-1:0] grant;
    logic [IdxW-1:0]   grant_idx;
    cpuif_req_t        sel_req;

    logic              busy;
    logic              any_ack;
    logic              tmo_hit;
    logic              done;
    logic              done_err;
    logic              issue_stall;

    i3c_rr_arbiter #(.NumReq(NumReq)) u_rr (
        .req        (s_req_i),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (grant[i]) grant_idx = IdxW'(i);
        end
    end

    always_comb begin
        sel_req.is_wr    = s_req_is_wr_i[grant_idx];
        sel_req.addr     = s_addr_i[grant_idx];
        sel_req.wr_data  = s_wr_data_i[grant_idx];
        sel_req.wr_biten = s_wr_biten_i[grant_idx];
    end

    // Completion logic. Any downstream ack in ISSUE/WAIT completes the owner as
    // the captured type; an ack of the other type is reported as an error.
    // A real ack in the timeout cycle wins, so tmo_hit excludes it.
    assign busy        = (state != ST_IDLE);
    assign any_ack     = m_cpuif_rd_ack | m_cpuif_wr_ack;
    assign tmo_hit     = busy && (cnt == CntW'(TimeoutCycles)) && !any_ack;
    assign done        = busy && (any_ack || tmo_hit);
    assign done_err    = cap.is_wr ? (~m_cpuif_wr_ack | m_cpuif_wr_err)
                                   : (~m_cpuif_rd_ack | m_cpuif_rd_err);
    assign issue_stall = cap.is_wr ? m_cpuif_req_stall_wr : m_cpuif_req_stall_rd;

    for (genvar i = 0; i < NumReq; i++) begin : g_rsp
        logic ack_here;
        assign ack_here      = done && (owner == IdxW'(i));
        assign s_rd_ack_o[i] = ack_here & ~cap.is_wr;
        assign s_wr_ack_o[i] = ack_here &  cap.is_wr;
        assign s_rd_err_o[i] = ack_here & ~cap.is_wr & done_err;
        assign s_wr_err_o[i] = ack_here &  cap.is_wr & done_err;
        assign s_stall_o[i]  = s_req_i[i] & ~ack_here;
    end

    assign s_rd_data_o = (done && !cap.is_wr && m_cpuif_rd_ack) ? m_cpuif_rd_data : '0;

    assign m_cpuif_req       = req_q;
    assign m_cpuif_req_is_wr = cap.is_wr;
    assign m_cpuif_addr      = cap.addr;
    assign m_cpuif_wr_data   = cap.wr_data;
    assign m_cpuif_wr_biten  = cap.wr_biten;
    assign timeout_o         = timeout_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_grant <= IdxW'(NumReq - 1);
            cap        <= '0;
            cnt        <= '0;
            req_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|s_req_i) begin
                        owner <= grant_idx;
                        cap   <= sel_req;
                        cnt   <= '0;
                        req_q <= 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (done) begin
                        req_q      <= 1'b0;
                        last_grant <= owner;
                        timeout_q  <= timeout_q | tmo_hit;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CntW'(1);
                        // Exactly one unstalled request cycle goes downstream.
                        if (!issue_stall) begin
                            req_q <= 1'b0;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (done) begin
                        last_grant <= owner;
                        timeout_q  <= timeout_q | tmo_hit;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_cpuif_arbiter.sv
// Scoreboard bench: stimulus pushes the expected upstream completion, a forked
// monitor pops and compares whenever an upstream ack appears.
module tb_csr_cpuif_arbiter;
    import I3CCSR_pkg::*;

    localparam int AW = I3CCSR_MIN_ADDR_WIDTH;
    localparam int DW = I3CCSR_DATA_WIDTH;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic [1:0]          s_req_i = '0;
    logic [1:0]          s_req_is_wr_i = '0;
    logic [1:0][AW-1:0]  s_addr_i = '0;
    logic [1:0][DW-1:0]  s_wr_data_i = '0;
    logic [1:0][DW-1:0]  s_wr_biten_i = '0;
    logic [1:0]          s_stall_o, s_rd_ack_o, s_rd_err_o, s_wr_ack_o, s_wr_err_o;
    logic [DW-1:0]       s_rd_data_o;
    logic                m_cpuif_req, m_cpuif_req_is_wr;
    logic [AW-1:0]       m_cpuif_addr;
    logic [DW-1:0]       m_cpuif_wr_data, m_cpuif_wr_biten;
    logic                m_cpuif_req_stall_wr = 1'b0, m_cpuif_req_stall_rd = 1'b0;
    logic                m_cpuif_rd_ack = 1'b0, m_cpuif_rd_err = 1'b0;
    logic                m_cpuif_wr_ack = 1'b0, m_cpuif_wr_err = 1'b0;
    logic [DW-1:0]       m_cpuif_rd_data = '0;
    logic                timeout_o;

    csr_cpuif_arbiter #(.NumReq(2), .TimeoutCycles(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_req_i(s_req_i), .s_req_is_wr_i(s_req_is_wr_i), .s_addr_i(s_addr_i),
        .s_wr_data_i(s_wr_data_i), .s_wr_biten_i(s_wr_biten_i),
        .s_stall_o(s_stall_o), .s_rd_ack_o(s_rd_ack_o), .s_rd_err_o(s_rd_err_o),
        .s_wr_ack_o(s_wr_ack_o), .s_wr_err_o(s_wr_err_o), .s_rd_data_o(s_rd_data_o),
        .m_cpuif_req(m_cpuif_req), .m_cpuif_req_is_wr(m_cpuif_req_is_wr),
        .m_cpuif_addr(m_cpuif_addr), .m_cpuif_wr_data(m_cpuif_wr_data),
        .m_cpuif_wr_biten(m_cpuif_wr_biten),
        .m_cpuif_req_stall_wr(m_cpuif_req_stall_wr), .m_cpuif_req_stall_rd(m_cpuif_req_stall_rd),
        .m_cpuif_rd_ack(m_cpuif_rd_ack), .m_cpuif_rd_err(m_cpuif_rd_err),
        .m_cpuif_wr_ack(m_cpuif_wr_ack), .m_cpuif_wr_err(m_cpuif_wr_err),
        .m_cpuif_rd_data(m_cpuif_rd_data), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          owner;
        bit          wr;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;
    int   ack_cyc = 0;
    int   req_cycles = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic monitor();
        exp_t       e;
        logic [1:0] oh;
        forever begin
            @(negedge clk_i);
            if (m_cpuif_req) req_cycles++;
            if (!rst_i && ((s_rd_ack_o | s_wr_ack_o) != 2'b00)) begin
                ack_cnt++;
                ack_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", {s_rd_ack_o, s_wr_ack_o}, 64'h0);
                end else begin
                    e  = exp_q.pop_front();
                    oh = 2'b01 << e.owner;
                    chk("ack_route",
                        {s_rd_ack_o, s_wr_ack_o, s_rd_err_o, s_wr_err_o},
                        {(e.wr ? 2'b00 : oh), (e.wr ? oh : 2'b00),
                         ((!e.wr && e.err) ? oh : 2'b00), ((e.wr && e.err) ? oh : 2'b00)});
                    chk("owner_unstalled", 64'(s_stall_o[e.owner]), 64'h0);
                    if (!e.wr && !e.err) chk("rd_data", s_rd_data_o, e.data);
                end
            end
        end
    endtask

    // Downstream regblock: optional stall, then ack after lat cycles in WAIT
    // (lat=0 acks in the unstalled ISSUE cycle). Call in the first ISSUE cycle.
    task automatic respond(input bit wr, input int stall_n, input int lat,
                           input logic [31:0] rdv, input bit wrong, input bit derr);
        for (int k = 0; k < stall_n; k++) begin
            m_cpuif_req_stall_wr = wr;
            m_cpuif_req_stall_rd = !wr;
            step();
        end
        m_cpuif_req_stall_wr = 1'b0;
        m_cpuif_req_stall_rd = 1'b0;
        for (int k = 0; k < lat; k++) step();
        if (wr ^ wrong) begin
            m_cpuif_wr_ack = 1'b1;
            m_cpuif_wr_err = derr;
        end else begin
            m_cpuif_rd_ack  = 1'b1;
            m_cpuif_rd_err  = derr;
            m_cpuif_rd_data = rdv;
        end
        step();
        m_cpuif_wr_ack  = 1'b0;
        m_cpuif_wr_err  = 1'b0;
        m_cpuif_rd_ack  = 1'b0;
        m_cpuif_rd_err  = 1'b0;
        m_cpuif_rd_data = '0;
    endtask

    task automatic push(input int owner, input bit wr, input bit err, input logic [31:0] data);
        exp_t e;
        e.owner = owner;
        e.wr    = wr;
        e.err   = err;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int r, input bit wr, input logic [AW-1:0] a, input logic [31:0] wd);
        s_req_is_wr_i[r] = wr;
        s_addr_i[r]      = a;
        s_wr_data_i[r]   = wd;
        s_wr_biten_i[r]  = 32'hFFFF_FFFF;
        s_req_i[r]       = 1'b1;
    endtask

    initial begin
        int base;
        bit found;
        int issue_cyc;
        int owner;

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst_m_req", 64'(m_cpuif_req), 64'h0);
        chk("rst_timeout", 64'(timeout_o), 64'h0);
        chk("rst_acks", {s_rd_ack_o, s_wr_ack_o, s_rd_err_o, s_wr_err_o}, 64'h0);
        step();

        // Single read from req0, ack one cycle after issue
        set_req(0, 1'b0, 12'h010, 32'h0);
        step();
        req_cycles = 0;
        chk("rd_issue_req", 64'(m_cpuif_req), 64'h1);
        chk("rd_issue_addr", 64'(m_cpuif_addr), 64'h010);
        chk("rd_issue_iswr", 64'(m_cpuif_req_is_wr), 64'h0);
        chk("rd_issue_stall", 64'(s_stall_o), 64'h1);
        push(0, 1'b0, 1'b0, 32'hCAFE_F00D);
        respond(1'b0, 0, 1, 32'hCAFE_F00D, 1'b0, 1'b0);
        s_req_i[0] = 1'b0;
        chk("rd_req_cycles", 64'(req_cycles), 64'h1);

        // Single write from req1, zero-latency ack
        step();
        set_req(1, 1'b1, 12'h014, 32'h1111_2222);
        step();
        chk("wr1_data", m_cpuif_wr_data, 64'h1111_2222);
        push(1, 1'b1, 1'b0, 32'h0);
        respond(1'b1, 0, 0, 32'h0, 1'b0, 1'b0);
        s_req_i[1] = 1'b0;

        // Both requesters hold 4 writes each: grants alternate starting at 0
        set_req(0, 1'b1, 12'h020, 32'hA0A0_0000);
        set_req(1, 1'b1, 12'h024, 32'hB1B1_0001);
        for (int n = 0; n < 8; n++) begin
            step();
            owner = n % 2;
            chk("rr_addr", 64'(m_cpuif_addr), (owner == 0) ? 64'h020 : 64'h024);
            chk("rr_both_stalled", 64'(s_stall_o), 64'h3);
            push(owner, 1'b1, 1'b0, 32'h0);
            respond(1'b1, 0, 0, 32'h0, 1'b0, 1'b0);
        end
        s_req_i = 2'b00;

        // Stalled write: 3 stall cycles -> 4 request cycles, one completion
        step();
        set_req(0, 1'b1, 12'h030, 32'h3030_3030);
        step();
        req_cycles = 0;
        base = ack_cnt;
        push(0, 1'b1, 1'b0, 32'h0);
        respond(1'b1, 3, 1, 32'h0, 1'b0, 1'b0);
        s_req_i[0] = 1'b0;
        chk("stall_req_cycles", 64'(req_cycles), 64'h4);
        chk("stall_one_completion", 64'(ack_cnt - base), 64'h1);

        // Read answered with a write ack -> read ack with error
        step();
        set_req(1, 1'b0, 12'h040, 32'h0);
        step();
        push(1, 1'b0, 1'b1, 32'h0);
        respond(1'b0, 0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        s_req_i[1] = 1'b0;

        // Downstream write error passes through
        step();
        set_req(0, 1'b1, 12'h044, 32'h4444_4444);
        step();
        push(0, 1'b1, 1'b1, 32'h0);
        respond(1'b1, 0, 0, 32'h0, 1'b0, 1'b1);
        s_req_i[0] = 1'b0;

        // Read with longer latency
        step();
        set_req(1, 1'b0, 12'h048, 32'h0);
        step();
        push(1, 1'b0, 1'b0, 32'h1234_5678);
        respond(1'b0, 0, 3, 32'h1234_5678, 1'b0, 1'b0);
        s_req_i[1] = 1'b0;

        // Timeout: no downstream answer, forced ack+err at issue+8
        step();
        set_req(0, 1'b1, 12'h050, 32'h5555_5555);
        step();
        issue_cyc = cyc;
        base = ack_cnt;
        found = 1'b0;
        push(0, 1'b1, 1'b1, 32'h0);
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (ack_cnt != base) found = 1'b1;
        end
        s_req_i[0] = 1'b0;
        chk("tmo_completed", 64'(found), 64'h1);
        chk("tmo_latency", 64'(ack_cyc - issue_cyc), 64'h8);
        chk("tmo_flag_set", 64'(timeout_o), 64'h1);

        // Flag stays set across a normal transaction
        step();
        set_req(1, 1'b1, 12'h054, 32'h0);
        step();
        push(1, 1'b1, 1'b0, 32'h0);
        respond(1'b1, 0, 0, 32'h0, 1'b0, 1'b0);
        s_req_i[1] = 1'b0;
        chk("tmo_flag_sticky", 64'(timeout_o), 64'h1);

        // Stray acks with nothing outstanding are ignored
        step();
        m_cpuif_rd_ack = 1'b1;
        m_cpuif_wr_ack = 1'b1;
        #1;
        chk("stray_no_ack", {s_rd_ack_o, s_wr_ack_o}, 64'h0);
        step();
        m_cpuif_rd_ack = 1'b0;
        m_cpuif_wr_ack = 1'b0;
        chk("stray_no_req", 64'(m_cpuif_req), 64'h0);
        set_req(0, 1'b0, 12'h058, 32'h0);
        step();
        chk("post_stray_issue", 64'(m_cpuif_req), 64'h1);
        push(0, 1'b0, 1'b0, 32'h0BAD_CAFE);
        respond(1'b0, 0, 0, 32'h0BAD_CAFE, 1'b0, 1'b0);
        s_req_i[0] = 1'b0;

        // Reset while waiting: transaction dropped with no ack
        step();
        set_req(0, 1'b0, 12'h05C, 32'h0);
        step();
        step();
        rst_i = 1'b1;
        #1;
        chk("rst_wait_req", 64'(m_cpuif_req), 64'h0);
        chk("rst_wait_timeout", 64'(timeout_o), 64'h0);
        m_cpuif_rd_ack = 1'b1;
        #1;
        chk("rst_wait_acks", {s_rd_ack_o, s_wr_ack_o}, 64'h0);
        @(negedge clk_i);
        chk("rst_wait_addr", 64'(m_cpuif_addr), 64'h0);
        m_cpuif_rd_ack = 1'b0;
        set_req(0, 1'b0, 12'h060, 32'h0);
        set_req(1, 1'b0, 12'h064, 32'h0);
        step();
        rst_i = 1'b0;
        step();
        chk("post_rst_first_grant", 64'(m_cpuif_addr), 64'h060);
        push(0, 1'b0, 1'b0, 32'h6060_6060);
        respond(1'b0, 0, 1, 32'h6060_6060, 1'b0, 1'b0);
        s_req_i[0] = 1'b0;
        step();
        chk("post_rst_second_grant", 64'(m_cpuif_addr), 64'h064);
        push(1, 1'b0, 1'b0, 32'h6464_6464);
        respond(1'b0, 0, 1, 32'h6464_6464, 1'b0, 1'b0);
        s_req_i[1] = 1'b0;

        repeat (3) step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
